// File: rtl/privilege_guard.sv
// rtl/privilege_guard.sv - ring-0/user privilege enforcer with fault latching
// Tracks kernel/user mode, gates jumps/memory/register writes and halts on violations.
module privilege_guard #(
   parameter int ADDR_W          = 16,
   parameter int SEL_W           = 5,
   parameter int RING0_PC_LAST   = 65535,
   parameter int RING0_ENTRY     = 0,
   parameter int RING0_MEM_LAST  = 0,
   parameter int RING0_REGS_LAST = 0,
   parameter int CNT_W           = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] io_pc,
   input  logic              io_jump,
   input  logic [ADDR_W-1:0] io_jumpTarget,
   input  logic              io_memValid,
   input  logic [ADDR_W-1:0] io_memAddress,
   input  logic              io_regValid,
   input  logic [SEL_W-1:0]  io_regASel,
   input  logic [SEL_W-1:0]  io_regBSel,
   input  logic              io_regWriteEnable,
   input  logic [SEL_W-1:0]  io_regWriteSel,
   input  logic              io_syscallReq,
   input  logic              io_faultAck,
   output logic              io_privileged,
   output logic              io_jumpAllow,
   output logic              io_memAllow,
   output logic              io_regWriteAllow,
   output logic [ADDR_W-1:0] io_programMemoryOffset,
   output logic [ADDR_W-1:0] io_dataMemoryOffset,
   output logic              io_halt,
   output logic              io_fault,
   output logic [2:0]        io_faultCause,
   output logic [ADDR_W-1:0] io_faultPc,
   output logic [ADDR_W-1:0] io_faultAddr,
   output logic [CNT_W-1:0]  io_faultCount
);

   localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(RING0_PC_LAST);
   localparam logic [ADDR_W-1:0] ENTRY     = ADDR_W'(RING0_ENTRY);
   localparam logic [ADDR_W-1:0] MEM_LAST  = ADDR_W'(RING0_MEM_LAST);
   localparam logic [SEL_W-1:0]  REGS_LAST = SEL_W'(RING0_REGS_LAST);
   localparam logic [ADDR_W-1:0] USER_BASE = ADDR_W'(RING0_PC_LAST + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {KERNEL, USER, FAULT} state_t;

   state_t            r_state;
   logic [2:0]        r_cause;
   logic [ADDR_W-1:0] r_fault_pc;
   logic [ADDR_W-1:0] r_fault_addr;
   logic [CNT_W-1:0]  r_count;

   logic [2:0]        w_cause;
   logic [ADDR_W-1:0] w_bad;
   logic              w_viol;
   logic              w_fault;

   // Checks only apply in USER; first matching cause wins.
   always_comb begin
      w_cause = 3'd0;
      w_bad   = '0;
      if (r_state == USER) begin
         if (io_jump && io_jumpTarget <= PC_LAST && io_jumpTarget != ENTRY) begin
            w_cause = 3'd1;
            w_bad   = io_jumpTarget;
         end else if (io_memValid && io_memAddress <= MEM_LAST) begin
            w_cause = 3'd2;
            w_bad   = io_memAddress;
         end else if (io_regWriteEnable && io_regWriteSel <= REGS_LAST) begin
            w_cause = 3'd3;
            w_bad   = ADDR_W'(io_regWriteSel);
         end else if (io_regValid && io_regASel <= REGS_LAST) begin
            w_cause = 3'd4;
            w_bad   = ADDR_W'(io_regASel);
         end else if (io_regValid && io_regBSel <= REGS_LAST) begin
            w_cause = 3'd5;
            w_bad   = ADDR_W'(io_regBSel);
         end
      end
   end

   assign w_viol  = (w_cause != 3'd0);
   assign w_fault = (r_state == FAULT);

   assign io_privileged          = (r_state == KERNEL);
   assign io_jumpAllow           = io_jump && !w_viol && !w_fault;
   assign io_memAllow            = io_memValid && !w_viol && !w_fault;
   assign io_regWriteAllow       = io_regWriteEnable && !w_viol && !w_fault;
   assign io_dataMemoryOffset    = (r_state == USER) ? USER_BASE : '0;
   assign io_programMemoryOffset = (r_state == USER && !io_syscallReq) ? USER_BASE : '0;
   assign io_halt                = w_viol || w_fault;
   assign io_fault               = w_fault;
   assign io_faultCause          = r_cause;
   assign io_faultPc             = r_fault_pc;
   assign io_faultAddr           = r_fault_addr;
   assign io_faultCount          = r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= KERNEL;
         r_cause      <= 3'd0;
         r_fault_pc   <= '0;
         r_fault_addr <= '0;
         r_count      <= '0;
      end else begin
         case (r_state)
            KERNEL: begin
               if (io_jump && io_jumpTarget > PC_LAST) r_state <= USER;
            end
            USER: begin
               if (w_viol) begin
                  r_state      <= FAULT;
                  r_cause      <= w_cause;
                  r_fault_pc   <= io_pc;
                  r_fault_addr <= w_bad;
                  if (r_count != CNT_MAX) r_count <= r_count + 1'b1;
               end else if (io_jump && io_jumpTarget == ENTRY) begin
                  r_state <= KERNEL;
               end
            end
            FAULT: begin
               if (io_faultAck) r_state <= KERNEL;
            end
            default: r_state <= KERNEL;
         endcase
      end
   end

endmodule

// File: tb/tb_privilege_guard.sv
// tb/tb_privilege_guard.sv - directed scoreboard bench for privilege_guard
module tb_privilege_guard;
   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] io_pc, io_jumpTarget, io_memAddress;
   logic        io_jump, io_memValid, io_regValid, io_regWriteEnable, io_syscallReq, io_faultAck;
   logic [4:0]  io_regASel, io_regBSel, io_regWriteSel;
   logic        io_privileged, io_jumpAllow, io_memAllow, io_regWriteAllow, io_halt, io_fault;
   logic [15:0] io_programMemoryOffset, io_dataMemoryOffset, io_faultPc, io_faultAddr;
   logic [2:0]  io_faultCause;
   logic [7:0]  io_faultCount;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   exp_cnt = 0;

   always #5 clock = ~clock;

   privilege_guard #(
      .ADDR_W(16), .SEL_W(5), .RING0_PC_LAST(255), .RING0_ENTRY(0),
      .RING0_MEM_LAST(63), .RING0_REGS_LAST(3), .CNT_W(8)
   ) dut (
      .clock(clock), .reset(reset), .io_pc(io_pc), .io_jump(io_jump),
      .io_jumpTarget(io_jumpTarget), .io_memValid(io_memValid), .io_memAddress(io_memAddress),
      .io_regValid(io_regValid), .io_regASel(io_regASel), .io_regBSel(io_regBSel),
      .io_regWriteEnable(io_regWriteEnable), .io_regWriteSel(io_regWriteSel),
      .io_syscallReq(io_syscallReq), .io_faultAck(io_faultAck),
      .io_privileged(io_privileged), .io_jumpAllow(io_jumpAllow), .io_memAllow(io_memAllow),
      .io_regWriteAllow(io_regWriteAllow), .io_programMemoryOffset(io_programMemoryOffset),
      .io_dataMemoryOffset(io_dataMemoryOffset), .io_halt(io_halt), .io_fault(io_fault),
      .io_faultCause(io_faultCause), .io_faultPc(io_faultPc), .io_faultAddr(io_faultAddr),
      .io_faultCount(io_faultCount)
   );

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      io_jump = 0; io_jumpTarget = 0; io_memValid = 0; io_memAddress = 0;
      io_regValid = 0; io_regASel = 5'd31; io_regBSel = 5'd31;
      io_regWriteEnable = 0; io_regWriteSel = 5'd31; io_syscallReq = 0; io_faultAck = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      idle();
      #1;
   endtask

   task automatic jump_user();
      io_jump = 1; io_jumpTarget = 16'd300;
      tick();
   endtask

   task automatic ack();
      io_faultAck = 1;
      tick();
   endtask

   task automatic fault_regs(input int cause, input int pc, input int addr, input int cnt);
      push("fault", 1);        pop_check(32'(io_fault));
      push("cause", cause);    pop_check(32'(io_faultCause));
      push("faultPc", pc);     pop_check(32'(io_faultPc));
      push("faultAddr", addr); pop_check(32'(io_faultAddr));
      push("faultCount", cnt); pop_check(32'(io_faultCount));
   endtask

   initial begin
      idle();
      io_pc = 0;
      reset = 1;
      tick(); tick();
      reset = 0;
      #1;
      push("rst_priv", 1);  pop_check(32'(io_privileged));
      push("rst_poff", 0);  pop_check(32'(io_programMemoryOffset));
      push("rst_doff", 0);  pop_check(32'(io_dataMemoryOffset));
      push("rst_fault", 0); pop_check(32'(io_fault));
      push("rst_halt", 0);  pop_check(32'(io_halt));
      push("rst_cause", 0); pop_check(32'(io_faultCause));
      push("rst_cnt", 0);   pop_check(32'(io_faultCount));
      push("rst_jallow", 0); pop_check(32'(io_jumpAllow));

      // Kernel -> user
      io_jump = 1; io_jumpTarget = 16'd300; #1;
      push("k_jallow", 1); pop_check(32'(io_jumpAllow));
      tick();
      push("u_priv", 0);   pop_check(32'(io_privileged));
      push("u_poff", 256); pop_check(32'(io_programMemoryOffset));
      push("u_doff", 256); pop_check(32'(io_dataMemoryOffset));

      // Syscall path back to kernel through entry
      io_syscallReq = 1; #1;
      push("sys_poff", 0);   pop_check(32'(io_programMemoryOffset));
      push("sys_doff", 256); pop_check(32'(io_dataMemoryOffset));
      io_jump = 1; io_jumpTarget = 0; #1;
      push("entry_jallow", 1); pop_check(32'(io_jumpAllow));
      push("entry_halt", 0);   pop_check(32'(io_halt));
      tick();
      push("entry_priv", 1); pop_check(32'(io_privileged));

      // Cause 1: illegal jump into ring 0
      jump_user();
      io_pc = 16'd400; io_jump = 1; io_jumpTarget = 16'd10; #1;
      push("c1_jallow", 0); pop_check(32'(io_jumpAllow));
      push("c1_halt", 1);   pop_check(32'(io_halt));
      exp_cnt++;
      tick();
      fault_regs(1, 400, 10, exp_cnt);
      push("c1_fault_halt", 1); pop_check(32'(io_halt));
      ack();
      push("ack_fault", 0); pop_check(32'(io_fault));
      push("ack_priv", 1);  pop_check(32'(io_privileged));

      // Cause 2 at boundary address 63
      jump_user();
      io_pc = 16'd500; io_memValid = 1; io_memAddress = 16'd63; #1;
      push("c2_mallow", 0); pop_check(32'(io_memAllow));
      exp_cnt++;
      tick();
      fault_regs(2, 500, 63, exp_cnt);
      ack();

      // Legal jump + memory violation: cause 2, jump blocked
      jump_user();
      io_pc = 16'd510; io_jump = 1; io_jumpTarget = 0; io_memValid = 1; io_memAddress = 16'd5; #1;
      push("jm_jallow", 0); pop_check(32'(io_jumpAllow));
      exp_cnt++;
      tick();
      fault_regs(2, 510, 5, exp_cnt);

      // Ack ignored outside FAULT? reset mid-FAULT returns to clean kernel
      reset = 1;
      tick();
      reset = 0;
      #1;
      exp_cnt = 0;
      push("rf_fault", 0); pop_check(32'(io_fault));
      push("rf_cnt", 0);   pop_check(32'(io_faultCount));
      push("rf_priv", 1);  pop_check(32'(io_privileged));

      // Fresh run: address 64 is legal
      jump_user();
      io_faultAck = 1;
      io_memValid = 1; io_memAddress = 16'd64; #1;
      push("m64_mallow", 1); pop_check(32'(io_memAllow));
      push("m64_halt", 0);   pop_check(32'(io_halt));
      tick();
      push("m64_fault", 0); pop_check(32'(io_fault));
      push("m64_priv", 0);  pop_check(32'(io_privileged));

      // Cause 3 beats cause 4; violation inside FAULT is ignored
      io_pc = 16'd600; io_regWriteEnable = 1; io_regWriteSel = 5'd3;
      io_regValid = 1; io_regASel = 5'd2; #1;
      push("c3_wallow", 0); pop_check(32'(io_regWriteAllow));
      exp_cnt++;
      tick();
      fault_regs(3, 600, 3, exp_cnt);
      io_pc = 16'd700; io_memValid = 1; io_memAddress = 16'd1; #1;
      push("inf_mallow", 0); pop_check(32'(io_memAllow));
      tick();
      push("inf_cnt", exp_cnt); pop_check(32'(io_faultCount));
      push("inf_cause", 3);     pop_check(32'(io_faultCause));
      ack();
      push("c3_ack_fault", 0); pop_check(32'(io_fault));

      // Cause 5: only B select is privileged
      jump_user();
      io_pc = 16'd610; io_regValid = 1; io_regASel = 5'd10; io_regBSel = 5'd1; #1;
      exp_cnt++;
      tick();
      fault_regs(5, 610, 1, exp_cnt);
      ack();

      // Saturation
      reset = 1;
      tick();
      reset = 0;
      exp_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         jump_user();
         io_memValid = 1; io_memAddress = 16'd0;
         tick();
         if (exp_cnt < 255) exp_cnt++;
         ack();
      end
      push("sat_cnt", exp_cnt); pop_check(32'(io_faultCount));
      push("sat_val", 255);     pop_check(32'(io_faultCount));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/privilege_guard.md
Name: privilege_guard

Overview:
- Synthesizable hardware enforcer for the ring-0/user protection model. It sits inside CPUTop between the control path and the program memory, data memory and register file.
- It tracks the current privilege mode and generates program/data memory offsets for user mode.
- It checks every jump, data access and register select against the ring-0 limits.
- On a violation it blocks the offending action, halts the core and latches fault information until software acknowledges it.

Parameters:
ADDR_W, 16, width of PC, jump target and data address
SEL_W, 5, register select width
RING0_PC_LAST, 65535, last privileged program address
RING0_ENTRY, 0, only legal user->kernel jump target
RING0_MEM_LAST, 0, last privileged data address
RING0_REGS_LAST, 0, last privileged register index
CNT_W, 8, fault counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
io_pc  in  ADDR_W  current program counter
io_jump  in  1  jump requested this cycle
io_jumpTarget  in  ADDR_W  requested jump address
io_memValid  in  1  data memory access this cycle
io_memAddress  in  ADDR_W  data address
io_regValid  in  1  register reads active this cycle
io_regASel  in  SEL_W  read port A select
io_regBSel  in  SEL_W  read port B select
io_regWriteEnable  in  1  register write this cycle
io_regWriteSel  in  SEL_W  write select
io_syscallReq  in  1  syscall pending (r31 > 0)
io_faultAck  in  1  handler acknowledges fault
io_privileged  out  1  1 = kernel mode
io_jumpAllow  out  1  gated jump to the PC
io_memAllow  out  1  gated memory enable
io_regWriteAllow  out  1  gated register write enable
io_programMemoryOffset  out  ADDR_W  program fetch offset
io_dataMemoryOffset  out  ADDR_W  data address offset
io_halt  out  1  stall core
io_fault  out  1  fault latched
io_faultCause  out  3  cause code
io_faultPc  out  ADDR_W  PC at the fault
io_faultAddr  out  ADDR_W  offending address or select, zero-extended
io_faultCount  out  CNT_W  saturating fault count

Behaviour:
- States: KERNEL, USER, FAULT. Reset forces KERNEL. Reset mid-FAULT also returns to KERNEL.
- Reset values: io_privileged=1, io_fault=0, io_halt=0, io_faultCause=0, io_faultPc=0, io_faultAddr=0, io_faultCount=0. Both offsets are 0 and all allow outputs are 0.
- USER_BASE = (RING0_PC_LAST+1) mod 2^ADDR_W. All comparisons are unsigned.
- Offsets are combinational from state:
  - KERNEL or FAULT: both offsets 0.
  - USER: io_dataMemoryOffset = USER_BASE. io_programMemoryOffset = 0 when io_syscallReq=1, otherwise USER_BASE.
- KERNEL: no checks. A jump with target > RING0_PC_LAST moves to USER on the next edge. Any other jump stays in KERNEL.
- USER checks, evaluated the same cycle. Priority order, first match wins:
  - cause 1: jump with target <= RING0_PC_LAST and target != RING0_ENTRY.
  - cause 2: memValid with address <= RING0_MEM_LAST.
  - cause 3: regWriteEnable with writeSel <= RING0_REGS_LAST.
  - cause 4: regValid with aSel <= RING0_REGS_LAST.
  - cause 5: regValid with bSel <= RING0_REGS_LAST.
- A legal USER jump to RING0_ENTRY moves to KERNEL on the next edge.
- Allow outputs:
  - io_jumpAllow = io_jump and no violation and not FAULT.
  - io_memAllow and io_regWriteAllow follow the same rule for their own request.
  - Any violation in a cycle blocks all three allows for that cycle.
- On a violation:
  - Next edge enters FAULT and latches cause, io_pc and the offending value.
  - io_faultCount increments and saturates at 2^CNT_W-1.
  - io_halt is combinationally 1 in the violation cycle and stays 1 throughout FAULT.
- FAULT:
  - io_fault=1 and io_halt=1.
  - New violations are ignored; they are neither counted nor re-latched.
  - io_faultAck=1 moves to KERNEL on the next edge and clears io_fault.
  - Cause, PC and address hold until the next fault. The count holds until reset.
- Simultaneous events:
  - io_faultAck while in USER or KERNEL is ignored.
  - A legal jump plus a memory violation in the same cycle faults with cause 2; the jump is blocked.

Test Plan:
All scenarios use RING0_PC_LAST=255, RING0_MEM_LAST=63, RING0_REGS_LAST=3.
- After reset: io_privileged=1 and both offsets 0. Jump to 300 -> next cycle io_privileged=0 and both offsets 256.
- In USER, raise io_syscallReq -> programMemoryOffset=0 and dataMemoryOffset=256. Jump to 0 -> jumpAllow=1, then KERNEL.
- In USER at pc=400, jump to 10 -> jumpAllow=0, halt=1 same cycle. Next cycle fault=1, cause=1, faultPc=400, faultAddr=10, faultCount=1.
- In USER: memValid with addr 63 -> cause 2, memAllow=0. Addr 64 in a fresh run -> no fault, memAllow=1.
- In USER: regWriteEnable with writeSel=3 and aSel=2 in the same cycle -> cause 3. During FAULT, inject a further violation -> count is unchanged. faultAck -> KERNEL, fault=0.
- Assert reset while in FAULT -> next cycle KERNEL, fault=0, faultCount=0. Drive 300 violations with ack between each -> count saturates at 255.
